// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//
// Zero-wait-state APB completer exposing a 64-byte window of sixteen 32-bit
// registers at BASE. The window holds thirteen general read/write registers,
// a STATUS register, a write counter and a constant ID register. Protocol
// violations set a sticky error bit that software clears by writing 1 to
// STATUS bit 0.
//
// Ports
//   hclk     in   single clock, all state changes on its rising edge
//   hresetn  in   asynchronous active-low reset (release synchronized outside)
//   psel     in   this slave's select line
//   penable  in   APB access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [31:0] byte address; [31:6] decoded, [5:2] index, [1:0] ignored
//   pwdata   in   [31:0] write data
//   prdata   out  [31:0] registered read data, non-zero only in read access cycles
//   err_irq  out  sticky protocol-error bit
//
// Register map (index = paddr[5:2])
//   0..12  general RW, reset 0
//   13     STATUS: bit0 sticky error (W1C), other bits read 0
//   14     WCOUNT: read-only count of committed writes, wraps at 32 bits
//   15     ID:     read-only, returns ID_VALUE
//
// FSM encoding: SETUP means "a setup phase was seen on the previous edge", so
// the cycle spent in SETUP is the APB access cycle. ACCESS is the cycle after a
// completed access, where a back-to-back setup may already be on the bus.
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter logic [31:0] BASE     = 32'h8000_0000,
    parameter logic [31:0] ID_VALUE = 32'hA0B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        err_irq
);

    localparam int NUM_GP = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;        // index latched at setup
    logic        wr_q, wr_d;          // direction latched at setup
    logic [31:0] regs_q [NUM_GP];
    logic [31:0] regs_d [NUM_GP];
    logic [31:0] wcount_q, wcount_d;
    logic        err_q, err_d;
    logic [31:0] prdata_q, prdata_d;

    logic        hit;
    logic        start_setup;
    logic [3:0]  idx;
    logic        err_set;
    logic        commit;
    logic [31:0] rd_mux;

    assign hit         = psel && (paddr[31:6] == BASE[31:6]);
    assign start_setup = hit && !penable;
    assign idx         = paddr[5:2];

    // Read mux on the live address: data is captured at the edge ending the
    // setup cycle, so a write committed one edge earlier is already visible.
    always_comb begin
        case (idx)
            4'd13:   rd_mux = {31'b0, err_q};
            4'd14:   rd_mux = wcount_q;
            4'd15:   rd_mux = ID_VALUE;
            default: rd_mux = regs_q[idx];
        endcase
    end

    // Next-state and transfer control.
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        err_set  = 1'b0;
        commit   = 1'b0;
        prdata_d = 32'h0;

        case (state_q)
            IDLE: begin
                if (start_setup) begin
                    state_d = SETUP;
                    idx_d   = idx;
                    wr_d    = pwrite;
                    if (!pwrite) prdata_d = rd_mux;
                end else if (hit && penable) begin
                    err_set = 1'b1;            // access without setup
                end
            end

            SETUP: begin
                if (hit && penable) begin
                    state_d = ACCESS;
                    if (idx != idx_q || pwrite != wr_q) begin
                        err_set = 1'b1;        // address/direction changed mid-transfer
                    end else if (pwrite) begin
                        commit = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    err_set = 1'b1;            // setup not followed by access
                end
            end

            ACCESS: begin
                if (start_setup) begin
                    state_d = SETUP;           // back-to-back transfer
                    idx_d   = idx;
                    wr_d    = pwrite;
                    if (!pwrite) prdata_d = rd_mux;
                end else begin
                    state_d = IDLE;
                    if (psel && penable) err_set = 1'b1;   // penable held too long
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Register file, write counter and sticky error.
    always_comb begin
        regs_d   = regs_q;
        wcount_d = wcount_q;
        err_d    = err_q;

        if (commit) begin
            wcount_d = wcount_q + 32'd1;   // counts ignored RO/STATUS writes too
            if (idx_q < 4'(NUM_GP)) begin
                regs_d[idx_q] = pwdata;
            end else if (idx_q == 4'd13 && pwdata[0]) begin
                err_d = 1'b0;
            end
        end

        // A new error outranks a W1C clear landing on the same edge.
        if (err_set) err_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    // NOTE: the general registers are plain flops, not a RAM macro, so they
    // can and must clear on the asynchronous reset.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            wr_q     <= 1'b0;
            wcount_q <= 32'h0;
            err_q    <= 1'b0;
            prdata_q <= 32'h0;
            for (int i = 0; i < NUM_GP; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            wcount_q <= wcount_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
            regs_q   <= regs_d;
        end
    end

    assign prdata  = prdata_q;
    assign err_irq = err_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regfile
//
// Self-checking bench for apb_slave_regfile. A table of directed transfers
// with hand-computed read data is applied first, followed by hand-written
// sequences for back-to-back traffic, protocol errors, counter wrap and
// reset in the middle of a transfer. Inputs change 1 ns after the rising
// edge; outputs are sampled at the same offset.
// ---------------------------------------------------------------------------
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ID   = 32'hA0B0_0001;

    logic        hclk;
    logic        hresetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        err_irq;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_wc;     // expected WCOUNT, stepped by every hit write
    logic [31:0] rd;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [14];

    apb_slave_regfile #(
        .BASE     (BASE),
        .ID_VALUE (ID)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .err_irq (err_irq)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input int cycles);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        repeat (cycles) tick();
    endtask

    // Setup + access; leaves the access-phase signals on the bus so the
    // caller may follow with another transfer (back-to-back) or idle().
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        tick();
        penable = 1'b1;
        tick();
        if (addr[31:6] == BASE[31:6]) exp_wc = exp_wc + 32'd1;
    endtask

    task automatic apb_read(input string name, input logic [31:0] addr, output logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        check({name, " prdata zero in setup"}, prdata, 32'h0);
        tick();
        penable = 1'b1;
        data    = prdata;
        tick();
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(name, addr, d);
        check(name, d, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_wc   = 32'h0;
        hresetn  = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 32'h0;
        pwdata   = 32'h0;

        vecs[0]  = '{1'b1, 32'h8000_0008, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 32'h8000_0008, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h8000_0038, 32'h0000_0001};
        vecs[3]  = '{1'b0, 32'h8000_003C, ID};
        vecs[4]  = '{1'b0, 32'h8000_0034, 32'h0000_0000};
        vecs[5]  = '{1'b1, 32'h9000_0000, 32'h1234_5678};   // non-hit write
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'h9000_0008, 32'h0000_0000};   // non-hit read
        vecs[8]  = '{1'b1, 32'h8000_003C, 32'h5555_5555};   // ID write ignored
        vecs[9]  = '{1'b0, 32'h8000_003C, ID};
        vecs[10] = '{1'b0, 32'h8000_0038, 32'h0000_0002};
        vecs[11] = '{1'b1, 32'h8000_0038, 32'h0000_0007};   // WCOUNT write ignored
        vecs[12] = '{1'b0, 32'h8000_0038, 32'h0000_0003};
        vecs[13] = '{1'b0, 32'h8000_000B, 32'hDEAD_BEEF};   // paddr[1:0] ignored

        // Reset state
        #23;
        check("reset prdata", prdata, 32'h0);
        check("reset err_irq", {31'b0, err_irq}, 32'h0);
        #4 hresetn = 1'b1;
        tick();
        read_check("reset reg0", 32'h8000_0000, 32'h0);
        read_check("reset wcount", 32'h8000_0038, 32'h0);
        idle(1);

        // Directed table, transfers issued back-to-back
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
            end
        end
        idle(1);
        check("vec prdata zero after access", prdata, 32'h0);
        check("vec no error", {31'b0, err_irq}, 32'h0);

        // Back-to-back writes to every general register, then ID and readback
        for (int i = 0; i < 13; i++) begin
            apb_write(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0001_0101);
        end
        read_check("b2b id", 32'h8000_003C, ID);
        read_check("b2b wcount", 32'h8000_0038, exp_wc);
        check("b2b wcount value", exp_wc, 32'd16);
        for (int i = 0; i < 13; i++) begin
            read_check($sformatf("b2b reg%0d", i), BASE + 32'(4 * i),
                       32'h1000_0000 + 32'(i) * 32'h0001_0101);
        end
        apb_write(32'h8000_0014, 32'h0BAD_F00D);
        read_check("read after write", 32'h8000_0014, 32'h0BAD_F00D);
        idle(1);

        // Access phase without setup
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0010;
        pwdata  = 32'hFFFF_FFFF;
        tick();
        check("no-setup err_irq", {31'b0, err_irq}, 32'h1);
        idle(1);
        read_check("no-setup no write", 32'h8000_0010, 32'h1004_0404);
        read_check("status set", 32'h8000_0034, 32'h1);
        apb_write(32'h8000_0034, 32'hFFFF_FFFE);
        read_check("status w0 keeps", 32'h8000_0034, 32'h1);
        apb_write(32'h8000_0034, 32'h0000_0001);
        idle(1);
        check("status w1c", {31'b0, err_irq}, 32'h0);

        // Address changed between setup and access
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0004;
        pwdata  = 32'h0000_0077;
        tick();
        penable = 1'b1;
        paddr   = 32'h8000_0008;
        tick();
        idle(1);
        check("addr change err", {31'b0, err_irq}, 32'h1);
        read_check("addr change reg1", 32'h8000_0004, 32'h1001_0101);
        read_check("addr change reg2", 32'h8000_0008, 32'h1002_0202);
        apb_write(32'h8000_0034, 32'h1);
        idle(1);
        check("clear 2", {31'b0, err_irq}, 32'h0);

        // penable held for a second cycle: write commits, error raised
        apb_write(32'h8000_0018, 32'h6666_6666);
        tick();
        check("penable held err", {31'b0, err_irq}, 32'h1);
        idle(1);
        read_check("penable held reg6", 32'h8000_0018, 32'h6666_6666);
        apb_write(32'h8000_0034, 32'h1);

        // Setup abandoned before access
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_001C;
        pwdata  = 32'h7777_7777;
        tick();
        idle(1);
        check("abandon err", {31'b0, err_irq}, 32'h1);
        read_check("abandon reg7", 32'h8000_001C, 32'h1007_0707);
        apb_write(32'h8000_0034, 32'h1);
        read_check("wcount after errors", 32'h8000_0038, exp_wc);
        idle(1);
        check("clear 4", {31'b0, err_irq}, 32'h0);

        // WCOUNT wrap, preloaded by forcing the counter over one idle edge
        force dut.wcount_q = 32'hFFFF_FFFE;
        idle(2);
        release dut.wcount_q;
        exp_wc = 32'hFFFF_FFFE;
        read_check("wrap preload", 32'h8000_0038, exp_wc);
        apb_write(32'h8000_0000, 32'h1);
        read_check("wrap max", 32'h8000_0038, 32'hFFFF_FFFF);
        apb_write(32'h8000_0000, 32'h2);
        read_check("wrap zero", 32'h8000_0038, 32'h0);
        idle(1);

        // Reset during the access cycle of a write to idx 3
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h8000_0000;
        tick();                          // error so reset has something to clear
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_000C;
        pwdata  = 32'hCAFE_F00D;
        tick();
        penable = 1'b1;
        #2 hresetn = 1'b0;
        #1;
        check("mid reset prdata", prdata, 32'h0);
        check("mid reset err_irq", {31'b0, err_irq}, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        @(posedge hclk);
        #4 hresetn = 1'b1;
        tick();
        exp_wc = 32'h0;
        read_check("mid reset reg3", 32'h8000_000C, 32'h0);
        read_check("mid reset reg0", 32'h8000_0000, 32'h0);
        read_check("mid reset wcount", 32'h8000_0038, 32'h0);
        apb_write(32'h8000_000C, 32'h3333_3333);
        read_check("post reset reg3", 32'h8000_000C, 32'h3333_3333);
        read_check("post reset wcount", 32'h8000_0038, exp_wc);
        idle(1);
        check("post reset err_irq", {31'b0, err_irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
